fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's synchronous show-ahead FIFO (`my_fifo`). It pops DATA_W-bit words from the FIFO read port and emits them as a valid/ready stream of OUT_W-bit beats. The reader sits between the FIFO and any narrower downstream consumer and turns FIFO empty/rden semantics into a back-pressurable stream with word-boundary marking.

---
 rtl/fifo_rd_pkg.sv | 22 ++
 rtl/fifo_stream_reader.sv | 116 +++++++++++
 tb/tb_fifo_stream_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and helpers for the FIFO stream reader
//
// Contents:
//   rd_state_t      - reader FSM states (RD_EMPTY: no word held, RD_HOLD: word held)
//   beats_per_word  - number of OUT_W beats in one DATA_W word
//   width_ok        - true when DATA_W is an integer multiple of OUT_W
package fifo_rd_pkg;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_HOLD  = 1'b1
    } rd_state_t;

    function automatic int beats_per_word(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    function automatic bit width_ok(input int data_w, input int out_w);
        return (out_w > 0) && (data_w >= out_w) && ((data_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a show-ahead FIFO into a valid/ready beat stream
//
// Pops DATA_W-bit words from a show-ahead FIFO and emits them as OUT_W-bit
// beats, marking the final beat of each word with o_last.
//
// Build option: FIFO_RD_MSB_FIRST_EN - when defined, beat 0 carries the most
// significant OUT_W bits of the word; otherwise beat 0 carries the LSBs.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   i_fifo_empty   FIFO empty flag
//   i_fifo_rddata  FIFO show-ahead read data
//   o_fifo_rden    FIFO pop strobe (combinational)
//   i_flush        discard the currently held word
//   o_valid        beat valid
//   o_data         beat data
//   o_last         final beat of the current word
//   i_ready        downstream accept
//   o_busy         a word is held (same as o_valid)
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
);

    localparam int R     = beats_per_word(DATA_W, OUT_W);
    localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(R - 1);

    if (!width_ok(DATA_W, OUT_W)) begin : g_width_check
        $fatal(1, "fifo_stream_reader: DATA_W must be an integer multiple of OUT_W");
    end

    rd_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] hold;
    logic              load;
    logic              accept;
    logic [CNT_W-1:0]  sel;
    logic [IDX_W-1:0]  bit_off;

    assign o_valid = (state == RD_HOLD);
    assign o_busy  = o_valid;
    // Gated with o_valid so o_last reads 0 whenever no word is held.
    assign o_last  = o_valid && (cnt == LAST_CNT);
    assign accept  = o_valid && i_ready;

    // Pop when idle, or when the last beat leaves this cycle so the next word
    // follows without a bubble. A flush suppresses the pop.
    assign o_fifo_rden = !i_fifo_empty && !i_flush &&
                         ((state == RD_EMPTY) || (accept && o_last));

`ifdef FIFO_RD_MSB_FIRST_EN
    assign sel = LAST_CNT - cnt;
`else
    assign sel = cnt;
`endif

    assign bit_off = IDX_W'(sel) * IDX_W'(OUT_W);
    assign o_data  = hold[bit_off +: OUT_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        if (i_flush) begin
            state_nxt = RD_EMPTY;
            cnt_nxt   = '0;
        end else if (o_fifo_rden) begin
            state_nxt = RD_HOLD;
            cnt_nxt   = '0;
            load      = 1'b1;
        end else if (accept) begin
            if (o_last) begin
                state_nxt = RD_EMPTY;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RD_EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (load) begin
            hold <= i_fifo_rddata;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    localparam int DATA_W = 128;
    localparam int OUT_W  = 32;
    localparam int R      = DATA_W / OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_fifo_empty = 1'b1;
    logic [DATA_W-1:0] i_fifo_rddata = '0;
    logic              o_fifo_rden;
    logic              i_flush = 1'b0;
    logic              o_valid;
    logic [OUT_W-1:0]  o_data;
    logic              o_last;
    logic              i_ready = 1'b0;
    logic              o_busy;

    fifo_stream_reader #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_rddata(i_fifo_rddata),
        .o_fifo_rden  (o_fifo_rden),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [OUT_W-1:0]  beats_q[$];

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Beat k of a word in emission order.
    function automatic logic [OUT_W-1:0] beat_of(input logic [DATA_W-1:0] w, input int k);
        logic [DATA_W-1:0] s;
`ifdef FIFO_RD_MSB_FIRST_EN
        s = w >> ((R - 1 - k) * OUT_W);
`else
        s = w >> (k * OUT_W);
`endif
        return s[OUT_W-1:0];
    endfunction

    // One clock cycle: drive inputs at the falling edge, check 1 time unit
    // later, update the reference after the rising edge.
    task automatic step(input logic rdy, input logic fl);
        logic exp_valid, exp_rden, empty, dut_rden;
        logic [DATA_W-1:0] head;
        empty = (fifo_q.size() == 0);
        head  = empty ? '0 : fifo_q[0];
        i_ready       = rdy;
        i_flush       = fl;
        i_fifo_empty  = empty;
        i_fifo_rddata = head;
        #1;
        exp_valid = (beats_q.size() != 0);
        exp_rden  = !empty && !fl && (!exp_valid || (rdy && beats_q.size() == 1));
        chk("valid", DATA_W'(o_valid), DATA_W'(exp_valid));
        chk("busy",  DATA_W'(o_busy),  DATA_W'(exp_valid));
        chk("rden",  DATA_W'(o_fifo_rden), DATA_W'(exp_rden));
        if (exp_valid) begin
            chk("data", DATA_W'(o_data), DATA_W'(beats_q[0]));
            chk("last", DATA_W'(o_last), DATA_W'(beats_q.size() == 1));
        end
        dut_rden = o_fifo_rden;
        @(posedge clk);
        if (fl) begin
            beats_q.delete();
        end else begin
            if (exp_valid && rdy) void'(beats_q.pop_front());
            if (exp_rden) for (int k = 0; k < R; k++) beats_q.push_back(beat_of(head, k));
        end
        if (dut_rden && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single word, continuous ready
        fifo_q.push_back(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        repeat (7) step(1'b1, 1'b0);

        // back-to-back words
        for (int i = 0; i < 3; i++) fifo_q.push_back(rand_word());
        repeat (15) step(1'b1, 1'b0);

        // back-pressure on beat 2, with another word waiting
        fifo_q.push_back(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        fifo_q.push_back(rand_word());
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);

        // flush on beat 1 of word A with word B queued
        fifo_q.push_back(rand_word());
        fifo_q.push_back(rand_word());
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0);

        // asynchronous reset in the middle of a word
        fifo_q.push_back(rand_word());
        repeat (3) step(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", DATA_W'(o_valid), '0);
        chk("rst_busy",  DATA_W'(o_busy), '0);
        chk("rst_last",  DATA_W'(o_last), '0);
        chk("rst_data",  DATA_W'(o_data), '0);
        beats_q.delete();
        fifo_q.delete();
        i_fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            chk("idle_data", DATA_W'(o_data), '0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 30 && fifo_q.size() < 8) fifo_q.push_back(rand_word());
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
